high_score_keeper: RTL and testbench

Downstream consumer of the running score counter.
- Tracks the best score of the session, latching it on each death.
- Converts the best score to five BCD digits with a sequential double-dabble engine, so the HI sprite stage indexes digit sprites directly with no combinational divide/modulo.
- Flags a new record for the HUD and provides a flash enable for it.
- Runs in the frame_Clk domain alongside the score counter.

---
 rtl/score_pkg.sv | 17 +
 rtl/bin2bcd_seq.sv | 81 ++++++++
 rtl/high_score_keeper.sv | 111 +++++++++++
 tb/tb_high_score_keeper.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared widths, limits and types for the high-score keeper and its BCD converter.
package score_pkg;

  localparam int SCORE_W    = 17;
  localparam int N_DIGITS   = 5;
  localparam int SCORE_MAX  = 99999;
  localparam int FLASH_HALF = 25;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per frame.
// The BCD output only changes in the DONE state, as a single 20-bit write.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int BIN_W  = 17,
  parameter int DIGITS = 5
) (
  input  logic                  frame_Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  shifting,
  output logic                  finishing
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t      state;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    sr_adj = sr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (sr[BIN_W + 4*d +: 4] >= 4'd5)
        sr_adj[BIN_W + 4*d +: 4] = sr[BIN_W + 4*d +: 4] + 4'd3;
    end
  end

  assign shifting  = (state == SHIFT);
  assign finishing = (state == DONE);

  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      bcd   <= '0;
      valid <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= {{BCD_W{1'b0}}, bin};
            cnt   <= '0;
            valid <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // The extra edge spent on the count check gives the fixed 19-frame latency.
          if (cnt == CNT_W'(BIN_W)) begin
            state <= DONE;
          end else begin
            sr  <= {sr_adj[SR_W-2:0], 1'b0};
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bcd <= sr[SR_W-1 -: BCD_W];
          if (start) begin
            sr    <= {{BCD_W{1'b0}}, bin};
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            valid <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/high_score_keeper.sv
// Session high-score tracker: captures the clipped score once per death,
// keeps a BCD copy for the HI sprites, and drives the new-record flash.
module high_score_keeper #(
  parameter int SCORE_W    = score_pkg::SCORE_W,
  parameter int N_DIGITS   = score_pkg::N_DIGITS,
  parameter int SCORE_MAX  = score_pkg::SCORE_MAX,
  parameter int FLASH_HALF = score_pkg::FLASH_HALF
) (
  input  logic                    frame_Clk,
  input  logic                    Reset,
  input  logic signed [31:0]      score_in,
  input  logic                    Dead,
  input  logic [1:0]              Game_State,
  input  logic                    clear_hi,
  output logic [SCORE_W-1:0]      hi_score,
  output logic [4*N_DIGITS-1:0]   hi_digits,
  output logic                    hi_valid,
  output logic                    new_record,
  output logic                    record_flash
);

  localparam int FC_W = $clog2(2 * FLASH_HALF);

  logic               Dead_d;
  logic [1:0]         gs_d;
  logic               pending;
  logic [FC_W-1:0]    flash_cnt;
  logic [SCORE_W-1:0] clipped;
  logic [SCORE_W-1:0] hi_next;
  logic               capture;
  logic               beat;
  logic               req;
  logic               run_start;
  logic               conv_shifting;
  logic               conv_finishing;

  always_comb begin
    if (score_in < 0)
      clipped = '0;
    else if (score_in > SCORE_MAX)
      clipped = SCORE_W'(SCORE_MAX);
    else
      clipped = score_in[SCORE_W-1:0];
  end

  assign capture   = Dead && !Dead_d;
  assign beat      = capture && !clear_hi && (clipped > hi_score);
  assign req       = clear_hi || beat;
  assign run_start = (Game_State == 2'b01) && ((gs_d == 2'b00) || (gs_d == 2'b10));

  always_comb begin
    hi_next = hi_score;
    if (clear_hi)
      hi_next = '0;
    else if (beat)
      hi_next = clipped;
  end

  // Converter always loads hi_next, so a reload in DONE picks up a same-edge update.
  bin2bcd_seq #(
    .BIN_W  (SCORE_W),
    .DIGITS (N_DIGITS)
  ) u_bcd (
    .frame_Clk (frame_Clk),
    .Reset     (Reset),
    .start     (req || pending),
    .bin       (hi_next),
    .bcd       (hi_digits),
    .valid     (hi_valid),
    .shifting  (conv_shifting),
    .finishing (conv_finishing)
  );

  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset) begin
      Dead_d     <= 1'b0;
      gs_d       <= 2'b00;
      hi_score   <= '0;
      new_record <= 1'b0;
      pending    <= 1'b0;
    end else begin
      Dead_d   <= Dead;
      gs_d     <= Game_State;
      hi_score <= hi_next;
      if (clear_hi)
        new_record <= 1'b0;
      else if (beat)
        new_record <= 1'b1;
      else if (run_start)
        new_record <= 1'b0;
      if (conv_finishing)
        pending <= 1'b0;
      else if (conv_shifting && req)
        pending <= 1'b1;
    end
  end

  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset)
      flash_cnt <= '0;
    else if (!new_record)
      flash_cnt <= '0;
    else if (flash_cnt == FC_W'(2 * FLASH_HALF - 1))
      flash_cnt <= '0;
    else
      flash_cnt <= flash_cnt + 1'b1;
  end

  assign record_flash = new_record && (flash_cnt < FC_W'(FLASH_HALF));

endmodule

// File: tb/tb_high_score_keeper.sv
// Directed plus randomized bench for high_score_keeper with an arithmetic reference model.
module tb_high_score_keeper;

  logic              frame_Clk;
  logic              Reset;
  logic signed [31:0] score_in;
  logic              Dead;
  logic [1:0]        Game_State;
  logic              clear_hi;
  logic [16:0]       hi_score;
  logic [19:0]       hi_digits;
  logic              hi_valid;
  logic              new_record;
  logic              record_flash;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int m_hi  = 0;
  bit m_rec = 0;

  high_score_keeper dut (
    .frame_Clk    (frame_Clk),
    .Reset        (Reset),
    .score_in     (score_in),
    .Dead         (Dead),
    .Game_State   (Game_State),
    .clear_hi     (clear_hi),
    .hi_score     (hi_score),
    .hi_digits    (hi_digits),
    .hi_valid     (hi_valid),
    .new_record   (new_record),
    .record_flash (record_flash)
  );

  initial frame_Clk = 1'b0;
  always #5 frame_Clk = ~frame_Clk;

  task automatic tick();
    @(posedge frame_Clk);
    #1;
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clip(input int s);
    if (s < 0) return 0;
    if (s > 99999) return 99999;
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one death edge and updates the model; returns whether a conversion starts.
  task automatic death_edge(input int s, output bit conv);
    int c;
    score_in = s;
    Dead     = 1'b1;
    tick();
    Dead = 1'b0;
    c = clip(s);
    conv = (c > m_hi);
    if (conv) begin
      m_hi  = c;
      m_rec = 1;
    end
  endtask

  initial begin
    bit conv;
    int r;
    int s;

    Reset = 1'b1; score_in = 0; Dead = 1'b0; Game_State = 2'b00; clear_hi = 1'b0;
    #1;
    check("rst_hi_score", 32'(hi_score), 0);
    check("rst_hi_digits", 32'(hi_digits), 0);
    check("rst_hi_valid", 32'(hi_valid), 1);
    #11 Reset = 1'b0;
    Game_State = 2'b01;
    for (int i = 0; i < 20; i++) tick();
    check("idle_hi_score", 32'(hi_score), 0);
    check("idle_hi_digits", 32'(hi_digits), 0);
    check("idle_hi_valid", 32'(hi_valid), 1);
    check("idle_new_record", 32'(new_record), 0);
    check("idle_flash", 32'(record_flash), 0);

    // First record, latency and flash cadence
    death_edge(1234, conv);
    check("d1234_hi_score", 32'(hi_score), 32'(m_hi));
    check("d1234_valid_low", 32'(hi_valid), 0);
    check("d1234_new_record", 32'(new_record), 1);
    check("d1234_flash_k0", 32'(record_flash), 1);
    for (int k = 1; k < 100; k++) begin
      tick();
      check("d1234_flash", 32'(record_flash), ((k % 50) < 25) ? 1 : 0);
      if (k < 19) begin
        check("d1234_valid_busy", 32'(hi_valid), 0);
        check("d1234_digits_hold", 32'(hi_digits), 0);
      end else if (k == 19) begin
        check("d1234_digits", 32'(hi_digits), 32'(to_bcd(1234)));
        check("d1234_valid_done", 32'(hi_valid), 1);
      end
    end

    // Lower score: no change
    death_edge(800, conv);
    check("d800_hi_score", 32'(hi_score), 1234);
    check("d800_valid", 32'(hi_valid), 1);
    check("d800_new_record", 32'(new_record), 1);
    tick(); tick();
    Game_State = 2'b10; tick();
    Game_State = 2'b01; tick();
    m_rec = 0;
    check("restart_new_record", 32'(new_record), 0);
    check("restart_flash", 32'(record_flash), 0);

    // Saturation at both ends
    death_edge(123456, conv);
    check("sat_hi_score", 32'(hi_score), 99999);
    for (int k = 1; k <= 19; k++) tick();
    check("sat_digits", 32'(hi_digits), 32'h99999);
    check("sat_valid", 32'(hi_valid), 1);
    death_edge(-5, conv);
    check("neg_hi_score", 32'(hi_score), 99999);
    check("neg_valid", 32'(hi_valid), 1);
    tick();

    // clear_hi beats a same-edge capture
    clear_hi = 1'b1; score_in = 300; Dead = 1'b1;
    tick();
    clear_hi = 1'b0; Dead = 1'b0;
    m_hi = 0; m_rec = 0;
    check("clr_hi_score", 32'(hi_score), 0);
    check("clr_new_record", 32'(new_record), 0);
    check("clr_valid", 32'(hi_valid), 0);
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 18) check("clr_digits_hold", 32'(hi_digits), 32'h99999);
    end
    check("clr_digits", 32'(hi_digits), 0);
    check("clr_valid_done", 32'(hi_valid), 1);

    // Request during conversion collapses into one re-conversion
    death_edge(500, conv);
    check("p500_hi_score", 32'(hi_score), 500);
    for (int k = 1; k <= 38; k++) begin
      if (k == 5) begin
        score_in = 700;
        Dead = 1'b1;
      end
      tick();
      Dead = 1'b0;
      if (k == 5) check("p700_hi_score", 32'(hi_score), 700);
      check("pend_digits", 32'(hi_digits),
            32'((k < 19) ? to_bcd(0) : (k < 38) ? to_bcd(500) : to_bcd(700)));
      check("pend_valid", 32'(hi_valid), (k < 38) ? 0 : 1);
    end
    m_hi = 700; m_rec = 1;
    check("pend_new_record", 32'(new_record), 1);

    // Randomized deaths, clears and restarts against the model
    for (int it = 0; it < 16; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        clear_hi = 1'b1;
        tick();
        clear_hi = 1'b0;
        m_hi = 0; m_rec = 0;
        for (int k = 1; k <= 19; k++) tick();
        check("rnd_clr_digits", 32'(hi_digits), 0);
      end else if (r == 1) begin
        Game_State = 2'b10; tick();
        Game_State = 2'b01; tick();
        m_rec = 0;
      end
      s = int'($urandom_range(0, 140000)) - 20000;
      death_edge(s, conv);
      check("rnd_hi_score", 32'(hi_score), 32'(m_hi));
      check("rnd_new_record", 32'(new_record), 32'(m_rec));
      check("rnd_valid_edge", 32'(hi_valid), conv ? 0 : 1);
      for (int k = 1; k <= 19; k++) tick();
      check("rnd_digits", 32'(hi_digits), 32'(to_bcd(m_hi)));
      check("rnd_valid_done", 32'(hi_valid), 1);
      check("rnd_flash_off", 32'(record_flash & ~new_record), 0);
    end

    // Reset in the middle of a conversion
    clear_hi = 1'b1; tick(); clear_hi = 1'b0;
    for (int k = 1; k <= 19; k++) tick();
    death_edge(4321, conv);
    for (int k = 1; k <= 8; k++) tick();
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_hi_score", 32'(hi_score), 0);
    check("mid_rst_digits", 32'(hi_digits), 0);
    check("mid_rst_valid", 32'(hi_valid), 1);
    check("mid_rst_new_record", 32'(new_record), 0);
    check("mid_rst_flash", 32'(record_flash), 0);
    #10 Reset = 1'b0;
    tick();
    check("post_rst_valid", 32'(hi_valid), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
